// File: rtl/dmem_pkg.sv
// Shared widths and the store-buffer entry record for the data-memory store buffer.
package dmem_pkg;

   localparam int unsigned ADDR_W   = 8;
   localparam int unsigned DATA_W   = 8;
   localparam int unsigned SB_DEPTH = 4;
   localparam int unsigned CNT_W    = 4;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } sb_entry_t;

endpackage

// File: rtl/store_fifo.sv
// Circular store FIFO: entry storage, valid bits, head/tail pointers and occupancy count.
module store_fifo
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH = SB_DEPTH
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push_i,
   input  logic                       pop_i,
   input  sb_entry_t                  push_entry_i,
   output sb_entry_t [DEPTH-1:0]      entry_o,
   output logic [DEPTH-1:0]           valid_o,
   output logic [$clog2(DEPTH)-1:0]   head_o,
   output logic [CNT_W-1:0]           count_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   sb_entry_t [DEPTH-1:0] entry_q;
   logic [DEPTH-1:0]      valid_q, valid_d;
   logic [PTR_W-1:0]      head_q, head_d;
   logic [PTR_W-1:0]      tail_q, tail_d;
   logic [CNT_W-1:0]      count_q, count_d;

   // Pop clears before push sets, so a full-buffer push+pop on the same slot stays valid.
   always_comb begin
      valid_d = valid_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (pop_i) begin
         valid_d[head_q] = 1'b0;
         head_d          = head_q + PTR_W'(1);
      end
      if (push_i) begin
         valid_d[tail_q] = 1'b1;
         tail_d          = tail_q + PTR_W'(1);
      end
      case ({push_i, pop_i})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         valid_q <= valid_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Payload needs no reset; valid bits qualify it.
   always_ff @(posedge clk) begin
      if (push_i) begin
         entry_q[tail_q] <= push_entry_i;
      end
   end

   assign entry_o = entry_q;
   assign valid_o = valid_q;
   assign head_o  = head_q;
   assign count_o = count_q;

endmodule

// File: rtl/dmem_store_buffer.sv
// Data memory with a store buffer: stores queue and drain when the single RAM port is idle,
// loads read the RAM or forward from the youngest matching buffered store.
module dmem_store_buffer
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH     = SB_DEPTH,
   parameter int unsigned MEM_WORDS = 256
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              MemWrite,
   input  logic [ADDR_W-1:0] ALUOut,
   input  logic [DATA_W-1:0] rd2_Data,
   input  logic              MemRead,
   output logic [DATA_W-1:0] ReadData,
   output logic              stall,
   output logic              overflow,
   output logic [CNT_W-1:0]  sb_count
);

   localparam int unsigned PTR_W  = $clog2(DEPTH);
   localparam int unsigned RAM_AW = $clog2(MEM_WORDS);

   logic [DATA_W-1:0]     ram_q [MEM_WORDS];
   sb_entry_t [DEPTH-1:0] entry;
   logic [DEPTH-1:0]      valid;
   logic [PTR_W-1:0]      head;
   logic [CNT_W-1:0]      count;

   logic                  full_c, drain_c, push_c;
   sb_entry_t             push_entry_c;
   logic                  fwd_hit_c;
   logic [DATA_W-1:0]     fwd_data_c;
   logic [DATA_W-1:0]     read_data_q, read_data_d;
   logic                  overflow_q, overflow_d;

   assign full_c       = (count == CNT_W'(DEPTH));
   assign drain_c      = (count != '0) && !MemRead;
   assign push_c       = MemWrite && (!full_c || drain_c);
   assign push_entry_c = '{addr: ALUOut, data: rd2_Data};

   store_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk          (clk),
      .rst_n        (rst),
      .push_i       (push_c),
      .pop_i        (drain_c),
      .push_entry_i (push_entry_c),
      .entry_o      (entry),
      .valid_o      (valid),
      .head_o       (head),
      .count_o      (count)
   );

   // Walk oldest to youngest so the last match wins.
   always_comb begin
      fwd_hit_c  = 1'b0;
      fwd_data_c = '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
         if (valid[head + PTR_W'(k)] && (entry[head + PTR_W'(k)].addr == ALUOut)) begin
            fwd_hit_c  = 1'b1;
            fwd_data_c = entry[head + PTR_W'(k)].data;
         end
      end
   end

   always_comb begin
      read_data_d = read_data_q;
      overflow_d  = overflow_q;
      if (MemRead) begin
         read_data_d = fwd_hit_c ? fwd_data_c : ram_q[RAM_AW'(ALUOut)];
      end
      if (MemWrite && full_c && !drain_c) begin
         overflow_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         read_data_q <= '0;
         overflow_q  <= 1'b0;
      end else begin
         read_data_q <= read_data_d;
         overflow_q  <= overflow_d;
      end
   end

   // Reset clears the count asynchronously, which also kills any pending drain write.
   always_ff @(posedge clk) begin
      if (drain_c) begin
         ram_q[RAM_AW'(entry[head].addr)] <= entry[head].data;
      end
   end

   assign ReadData = read_data_q;
   assign overflow = overflow_q;
   assign stall    = full_c;
   assign sb_count = count;

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Directed bench for dmem_store_buffer: store/load, forwarding, full, overflow, reset, wrap.
module tb_dmem_store_buffer;

   logic       clk;
   logic       rst;
   logic       MemWrite;
   logic [7:0] ALUOut;
   logic [7:0] rd2_Data;
   logic       MemRead;
   logic [7:0] ReadData;
   logic       stall;
   logic       overflow;
   logic [3:0] sb_count;

   int n_checks = 0;
   int n_fail   = 0;

   dmem_store_buffer #(.DEPTH(4), .MEM_WORDS(256)) dut (
      .clk      (clk),
      .rst      (rst),
      .MemWrite (MemWrite),
      .ALUOut   (ALUOut),
      .rd2_Data (rd2_Data),
      .MemRead  (MemRead),
      .ReadData (ReadData),
      .stall    (stall),
      .overflow (overflow),
      .sb_count (sb_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Inputs change at negedge; outputs are sampled at the following negedge.
   task automatic tick;
      @(negedge clk);
   endtask

   task automatic test_reset;
      rst = 1'b1; MemWrite = 1'b0; MemRead = 1'b0; ALUOut = '0; rd2_Data = '0;
      #2 rst = 1'b0;
      #1;
      n_checks++; if (ReadData !== 8'h00) begin n_fail++; $display("FAIL reset_rd: got %0h want 0", ReadData); end
      n_checks++; if (sb_count !== 4'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", sb_count); end
      n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %0b want 0", stall); end
      n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %0b want 0", overflow); end
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_store_load;
      MemWrite = 1'b1; ALUOut = 8'h10; rd2_Data = 8'h5A; MemRead = 1'b0;
      tick;
      n_checks++; if (sb_count !== 4'd1) begin n_fail++; $display("FAIL sl_cnt1: got %0d want 1", sb_count); end
      MemWrite = 1'b0;
      tick;
      n_checks++; if (sb_count !== 4'd0) begin n_fail++; $display("FAIL sl_cnt0: got %0d want 0", sb_count); end
      MemRead = 1'b1;
      tick;
      n_checks++; if (ReadData !== 8'h5A) begin n_fail++; $display("FAIL sl_load: got %0h want 5a", ReadData); end
      MemRead = 1'b0; ALUOut = 8'h00;
      tick;
      n_checks++; if (ReadData !== 8'h5A) begin n_fail++; $display("FAIL sl_hold: got %0h want 5a", ReadData); end
   endtask

   task automatic test_forwarding;
      MemWrite = 1'b1; ALUOut = 8'h20; rd2_Data = 8'h99; MemRead = 1'b0;
      tick;
      MemWrite = 1'b0;
      tick;
      MemRead = 1'b1; MemWrite = 1'b1; rd2_Data = 8'h11;
      tick;
      n_checks++; if (ReadData !== 8'h99) begin n_fail++; $display("FAIL fwd_prestore: got %0h want 99", ReadData); end
      n_checks++; if (sb_count !== 4'd1) begin n_fail++; $display("FAIL fwd_cnt1: got %0d want 1", sb_count); end
      rd2_Data = 8'h22;
      tick;
      n_checks++; if (ReadData !== 8'h11) begin n_fail++; $display("FAIL fwd_first: got %0h want 11", ReadData); end
      n_checks++; if (sb_count !== 4'd2) begin n_fail++; $display("FAIL fwd_cnt2: got %0d want 2", sb_count); end
      MemWrite = 1'b0;
      tick;
      n_checks++; if (ReadData !== 8'h22) begin n_fail++; $display("FAIL fwd_youngest: got %0h want 22", ReadData); end
      MemRead = 1'b0;
      tick;
      tick;
      n_checks++; if (sb_count !== 4'd0) begin n_fail++; $display("FAIL fwd_drained: got %0d want 0", sb_count); end
      MemRead = 1'b1;
      tick;
      n_checks++; if (ReadData !== 8'h22) begin n_fail++; $display("FAIL fwd_ram: got %0h want 22", ReadData); end
      MemRead = 1'b0;
   endtask

   task automatic test_full_drain;
      int n;
      MemRead = 1'b1;
      for (int i = 0; i < 4; i++) begin
         MemWrite = 1'b1; ALUOut = 8'h40 + 8'(i); rd2_Data = 8'hA0 + 8'(i);
         tick;
      end
      n_checks++; if (sb_count !== 4'd4) begin n_fail++; $display("FAIL fd_cnt_full: got %0d want 4", sb_count); end
      n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL fd_stall_full: got %0b want 1", stall); end
      MemRead = 1'b0; ALUOut = 8'h30; rd2_Data = 8'h77;
      tick;
      n_checks++; if (sb_count !== 4'd4) begin n_fail++; $display("FAIL fd_cnt_keep: got %0d want 4", sb_count); end
      n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL fd_stall_keep: got %0b want 1", stall); end
      n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fd_ovf: got %0b want 0", overflow); end
      MemWrite = 1'b0;
      n = 0;
      while (sb_count != 4'd0 && n < 10) begin tick; n++; end
      n_checks++; if (sb_count !== 4'd0) begin n_fail++; $display("FAIL fd_drain_timeout: got %0d want 0", sb_count); end
      MemRead = 1'b1; ALUOut = 8'h30;
      tick;
      n_checks++; if (ReadData !== 8'h77) begin n_fail++; $display("FAIL fd_load30: got %0h want 77", ReadData); end
      ALUOut = 8'h40;
      tick;
      n_checks++; if (ReadData !== 8'hA0) begin n_fail++; $display("FAIL fd_load40: got %0h want a0", ReadData); end
      ALUOut = 8'h43;
      tick;
      n_checks++; if (ReadData !== 8'hA3) begin n_fail++; $display("FAIL fd_load43: got %0h want a3", ReadData); end
      MemRead = 1'b0;
   endtask

   task automatic test_full_overflow;
      MemRead = 1'b0;
      for (int i = 0; i < 5; i++) begin
         MemWrite = 1'b1; ALUOut = 8'h60 + 8'(i); rd2_Data = 8'h30 + 8'(i);
         tick;
      end
      MemWrite = 1'b0;
      tick;
      n_checks++; if (sb_count !== 4'd0) begin n_fail++; $display("FAIL ov_preload: got %0d want 0", sb_count); end
      MemRead = 1'b1;
      for (int i = 0; i < 5; i++) begin
         MemWrite = 1'b1; ALUOut = 8'h60 + 8'(i); rd2_Data = 8'hE0 + 8'(i);
         tick;
         if (i == 3) begin
            n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL ov_stall4: got %0b want 1", stall); end
            n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ov_early: got %0b want 0", overflow); end
         end
      end
      MemWrite = 1'b0;
      n_checks++; if (sb_count !== 4'd4) begin n_fail++; $display("FAIL ov_cnt: got %0d want 4", sb_count); end
      n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ov_set: got %0b want 1", overflow); end
      n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL ov_stall5: got %0b want 1", stall); end
      n_checks++; if (ReadData !== 8'h34) begin n_fail++; $display("FAIL ov_load64: got %0h want 34", ReadData); end
   endtask

   task automatic test_reset_midrun;
      logic [7:0] exp [5];
      exp = '{8'hE0, 8'h31, 8'h32, 8'h33, 8'h34};
      MemRead = 1'b1; ALUOut = 8'h61;
      tick;
      n_checks++; if (ReadData !== 8'hE1) begin n_fail++; $display("FAIL rm_fwd: got %0h want e1", ReadData); end
      MemRead = 1'b0;
      tick;
      n_checks++; if (sb_count !== 4'd3) begin n_fail++; $display("FAIL rm_cnt3: got %0d want 3", sb_count); end
      n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL rm_sticky: got %0b want 1", overflow); end
      #2 rst = 1'b0;
      #1;
      n_checks++; if (ReadData !== 8'h00) begin n_fail++; $display("FAIL rm_rd: got %0h want 0", ReadData); end
      n_checks++; if (sb_count !== 4'd0) begin n_fail++; $display("FAIL rm_cnt: got %0d want 0", sb_count); end
      n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rm_stall: got %0b want 0", stall); end
      n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rm_ovf: got %0b want 0", overflow); end
      tick;
      rst = 1'b1;
      MemRead = 1'b1;
      for (int i = 0; i < 5; i++) begin
         ALUOut = 8'h60 + 8'(i);
         tick;
         n_checks++;
         if (ReadData !== exp[i]) begin
            n_fail++; $display("FAIL rm_ram%0d: got %0h want %0h", i, ReadData, exp[i]);
         end
      end
      MemRead = 1'b0;
   endtask

   task automatic test_wrap;
      MemRead = 1'b0;
      for (int i = 0; i < 10; i++) begin
         MemWrite = 1'b1; ALUOut = 8'(i); rd2_Data = 8'hB0 + 8'(i);
         tick;
      end
      n_checks++; if (sb_count !== 4'd1) begin n_fail++; $display("FAIL wr_cnt1: got %0d want 1", sb_count); end
      MemWrite = 1'b0;
      tick;
      n_checks++; if (sb_count !== 4'd0) begin n_fail++; $display("FAIL wr_cnt0: got %0d want 0", sb_count); end
      MemRead = 1'b1;
      for (int i = 0; i < 10; i++) begin
         ALUOut = 8'(i);
         tick;
         n_checks++;
         if (ReadData !== 8'hB0 + 8'(i)) begin
            n_fail++; $display("FAIL wr_load%0d: got %0h want %0h", i, ReadData, 8'hB0 + 8'(i));
         end
      end
      MemRead = 1'b0;
   endtask

   initial begin
      test_reset;
      test_store_load;
      test_forwarding;
      test_full_drain;
      test_full_overflow;
      test_reset_midrun;
      test_wrap;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/dmem_store_buffer.md
DMEM_STORE_BUFFER -- requirements
Module: dmem_store_buffer

Interface
REQ-001 Parameter DEPTH, default 4, number of store-buffer entries (power of two, 2..8).
REQ-002 Parameter MEM_WORDS, default 256, data-memory size in bytes (address width 8).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low.
REQ-005 MemWrite  input  1  CPU store strobe, one store per cycle while high.
REQ-006 ALUOut  input  8  CPU load/store byte address.
REQ-007 rd2_Data  input  8  CPU store data.
REQ-008 MemRead  input  1  CPU load strobe.
REQ-009 ReadData  output  8  registered load result.
REQ-010 stall  output  1  buffer full; CPU holds its store while high.
REQ-011 overflow  output  1  sticky: a store was dropped.
REQ-012 sb_count  output  4  number of occupied buffer entries.

Function
REQ-013 The block SHALL own a single-port MEM_WORDS x 8 RAM array with one access (read or write) per cycle.
REQ-014 Stores SHALL enter a circular FIFO of DEPTH entries {addr, data}; the oldest entry drains to RAM.
REQ-015 Drain: in any cycle with sb_count>0 and MemRead=0, the head entry SHALL be written to RAM at that edge and popped.
REQ-016 In a cycle with MemRead=1 the RAM port SHALL serve the read; no drain occurs.
REQ-017 Push: MemWrite=1 SHALL be accepted when sb_count<DEPTH, or when sb_count=DEPTH and a drain occurs in the same cycle.
REQ-018 A store with MemWrite=1, sb_count=DEPTH and no drain SHALL be dropped and set overflow=1 at that edge.
REQ-019 Simultaneous push and drain SHALL leave sb_count unchanged; pointers wrap modulo DEPTH.
REQ-020 stall SHALL equal (sb_count==DEPTH), combinationally from the registered count.
REQ-021 Load latency SHALL be one cycle: at the edge where MemRead=1, ReadData captures the result; otherwise ReadData holds.
REQ-022 Load forwarding: if ALUOut matches one or more valid buffer entries, ReadData SHALL take the data of the youngest match; else the RAM byte.
REQ-023 A store and load to the same address in the same cycle SHALL return the pre-store value (store is younger than the load).
REQ-024 MemRead and MemWrite both high SHALL perform both: load per REQ-022/023, store per REQ-017/018.
REQ-025 overflow SHALL remain 1 until reset.

Reset
REQ-026 rst low SHALL immediately clear: ReadData=0, sb_count=0, head/tail pointers=0, all entry valid bits=0, overflow=0.
REQ-027 Pending undrained stores SHALL be discarded on reset; RAM contents SHALL NOT be reset.
REQ-028 Reset asserted mid-drain SHALL abort that write; no partial RAM update.

Structure
REQ-029 Package dmem_pkg SHALL hold ADDR_W=8, DATA_W=8, default DEPTH and the store-entry record type {addr, data}.
REQ-030 FIFO storage, pointers and count SHALL live in sub-module store_fifo; forwarding compare and RAM stay in dmem_store_buffer.

Verification
REQ-031 Reset: rst low mid-run with 3 entries -> ReadData=0, sb_count=0, stall=0, overflow=0 immediately; stale stores never reach RAM.
REQ-032 Store then load: store 0x5A to 0x10, MemRead idle one cycle, then load 0x10 -> ReadData=0x5A one cycle after the load.
REQ-033 Forwarding: hold MemRead=1 on 0x20 while storing 0x11 then 0x22 to 0x20 -> the load after the second store returns 0x22 (youngest); the load in the cycle of the first store returns the pre-store RAM value.
REQ-034 Full/overflow: MemRead=1 continuously, 5 stores with DEPTH=4 -> stall=1 after 4th, 5th dropped, overflow=1, sb_count=4.
REQ-035 Full with drain: sb_count=4, MemRead=0, store 0x77 to 0x30 -> accepted, sb_count stays 4, stall stays 1, overflow stays 0.
REQ-036 Wrap-around: 10 back-to-back stores to addresses 0..9 with MemRead=0 -> all drain in order; subsequent loads return each stored byte.
